wshb_arbiter: RTL

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wshb_arbiter.sv
// wshb_arbiter -- two-master Wishbone arbiter onto one shared slave.
//
// Purpose:
//   Grants the shared slave to one of two Wishbone masters. Simultaneous
//   requests are settled round-robin. A master that has collected MAX_BURST
//   acks is pre-empted when the other master is waiting. Every change of
//   ownership passes through at least one cycle with s_cyc=0.
//
// Handshake: a transfer completes on a cycle where the owner's cyc and stb
//   are high and the slave returns s_ack. Only the current owner ever sees
//   an ack. A master that is not granted keeps its stb pending until it
//   owns the bus again.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mN_cyc/stb/we/adr/sel/dat_ms/cti/bte   master N request side (N=0,1)
//   mN_dat_sm, mN_ack          read data and ack returned to master N
//   s_cyc/stb/we/adr/sel/dat_ms/cti/bte    shared slave request side
//   s_dat_sm, s_ack            shared slave response side
//   grant                      one-hot owner (bit0=m0, bit1=m1), 00 idle
//   dbg_state                  current FSM state (IDLE=0 GNT0=1 GNT1=2 GAP=3)

module wshb_arbiter #(
    parameter int MAX_BURST = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_dat_ms,
    input  logic [2:0]  m0_cti,
    input  logic [1:0]  m0_bte,
    output logic [31:0] m0_dat_sm,
    output logic        m0_ack,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_dat_ms,
    input  logic [2:0]  m1_cti,
    input  logic [1:0]  m1_bte,
    output logic [31:0] m1_dat_sm,
    output logic        m1_ack,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [3:0]  s_sel,
    output logic [31:0] s_dat_ms,
    output logic [2:0]  s_cti,
    output logic [1:0]  s_bte,
    input  logic [31:0] s_dat_sm,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = MAX_BURST[CW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last1_q, last1_d;   // 1: m1 was served last, so m0 wins a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          win1;
    logic          any_req;

    // Saturating increment of the owner's ack count.
    assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + CW'(1);

    // Arbitration used from both IDLE and GAP.
    assign any_req = m0_cyc | m1_cyc;
    assign win1    = (m1_cyc & ~m0_cyc) | (m0_cyc & m1_cyc & ~last1_q);

    always_comb begin
        state_d = state_q;
        last1_d = last1_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d = win1 ? GNT1 : GNT0;
                    last1_d = win1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_d = GAP;
                end else if (m0_ack) begin
                    cnt_d = cnt_inc;
                    // Pre-empt on the ack that completes the burst allowance.
                    if (cnt_inc == MAX_C && m1_cyc) state_d = GAP;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_d = GAP;
                end else if (m1_ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_C && m0_cyc) state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last1_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last1_q <= last1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave request mux: owner's signals straight through, all zero otherwise.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_ms = '0;
        s_cti    = '0;
        s_bte    = '0;
        case (state_q)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_ms = m0_dat_ms;
                s_cti    = m0_cti;
                s_bte    = m0_bte;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_ms = m1_dat_ms;
                s_cti    = m1_cti;
                s_bte    = m1_bte;
            end
            default: ;
        endcase
    end

    assign m0_ack    = s_ack & (state_q == GNT0) & s_stb;
    assign m1_ack    = s_ack & (state_q == GNT1) & s_stb;
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

    assign grant     = {state_q == GNT1, state_q == GNT0};
    assign dbg_state = state_q;

endmodule
